avl_mem_slave: RTL
==================

Name: avl_mem_slave

Overview:
- Avalon-MM responder (slave) backed by an on-chip word-addressed memory array.
- Terminates the 32-bit Avalon master bus driven by the CPU-side bridge (address, byteenable, lock, read, write, burstcount in; readdata, response, waitrequest, readdatavalid, writeresponsevalid out).
- Used as simulation and FPGA stand-in for external memory.
- Supports incrementing bursts, programmable wait-state insertion, write responses, and decode-error signalling.

Parameters:
- DEPTH, 1024, memory size in 32-bit words (power of two).
- WAIT_CYCLES, 0, waitrequest cycles inserted before each command is accepted (0..15).
- MAX_BURST, 4, largest legal burstcount (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- s_avl_address  in  32  byte address; bits [1:0] ignored.
- s_avl_byteenable  in  4  write byte lanes.
- s_avl_lock  in  1  accepted, no effect (single master).
- s_avl_read  in  1  read request.
- s_avl_writedata  in  32  write data.
- s_avl_write  in  1  write request.
- s_avl_burstcount  in  3  beats; 0 treated as 1.
- s_avl_readdata  out  32  read data.
- s_avl_response  out  2  00 OKAY, 10 SLAVEERROR, 11 DECODEERROR.
- s_avl_waitrequest  out  1  stall; master holds all request signals while high.
- s_avl_readdatavalid  out  1  one pulse per read beat.
- s_avl_writeresponsevalid  out  1  one pulse per completed write burst.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, wait counter 0, waitrequest=1, readdatavalid=0, writeresponsevalid=0, readdata=0, response=00. Memory contents are preserved. Reset mid-burst abandons the burst: no further valid pulses and no write response.
- States: IDLE, WAIT, WRITE, READ, WRESP.
- IDLE: waitrequest=1 unless WAIT_CYCLES=0.
  - On read or write: go to WAIT and count up.
  - With WAIT_CYCLES=0, waitrequest=0 combinationally and the command is accepted in the same cycle.
- WAIT: waitrequest drops in the cycle the counter equals WAIT_CYCLES. The command is accepted on that edge.
- Acceptance latches the following:
  - base word index = address[log2(DEPTH)+1:2];
  - beats = burstcount (0→1);
  - err = 11 if address >= DEPTH*4;
  - else err = 10 if burstcount > MAX_BURST;
  - else err = 00.
- Write command:
  - The first data beat is taken at acceptance.
  - If beats>1, go to WRITE. There waitrequest=0 and each cycle with write=1 takes one beat. Cycles with write=0 are idle, not errors.
  - Beat k writes word (base+k) mod DEPTH. Only byte lanes with byteenable=1 are written.
  - No write occurs if err≠00.
  - After the last beat, go to WRESP: writeresponsevalid=1 for exactly one cycle, response=err. Then return to IDLE.
- Read command:
  - Go to READ with waitrequest=1.
  - Readdatavalid is high for exactly `beats` consecutive cycles, starting the cycle after acceptance.
  - Beat k returns mem[(base+k) mod DEPTH], with response=err. Readdata=0 when err≠00.
  - After the last beat, return to IDLE.
- waitrequest is 1 in READ and WRESP; new commands are not accepted until IDLE.
- Read and write asserted together: write wins; the read is ignored.
- A read of a word written in the same cycle returns the new data.
- response and readdata hold their last values when no valid is asserted.
- Throughput: back-to-back single reads with WAIT_CYCLES=0 complete one per 2 cycles.

Test Plan:
- Reset, WAIT_CYCLES=0. Write 0xDEADBEEF to 0x10 with byteenable 1111 → writeresponsevalid pulses 1 cycle after acceptance with response 00. Read 0x10 → readdatavalid the next cycle, readdata 0xDEADBEEF, response 00.
- Byteenable 0101 write of 0x11223344 over 0xDEADBEEF at 0x10 → readback 0xDE22BE44.
- Write burstcount 4 at 0x20 with data 1,2,3,4, including one idle cycle (write=0) between beats 2 and 3 → exactly one write response after beat 4. Read burst 4 → four consecutive readdatavalid cycles returning 1,2,3,4.
- Burst wrap: DEPTH=1024, read burstcount 2 at 0xFFC → beats return mem[1023], then mem[0].
- Address 0x1000 with DEPTH=1024 → read returns readdata 0, response 11; write leaves memory unchanged, write response 11. Burstcount 6 with MAX_BURST=4 → 6 read beats, each with response 10.
- WAIT_CYCLES=3: read held high → waitrequest high 3 cycles, low on the 4th, readdatavalid on the 5th. Assert rst=0 mid read burst (after beat 2 of 4) → readdatavalid=0 and waitrequest=1 immediately, no further beats after reset release.

Source files
------------

// File: rtl/avl_mem_slave.sv
// Avalon-MM responder backed by a word-addressed on-chip memory: incrementing bursts,
// programmable wait states, write responses and decode/slave error reporting.
module avl_mem_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int MAX_BURST   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_avl_address,
    input  logic [3:0]  s_avl_byteenable,
    input  logic        s_avl_lock,
    input  logic        s_avl_read,
    input  logic [31:0] s_avl_writedata,
    input  logic        s_avl_write,
    input  logic [2:0]  s_avl_burstcount,
    output logic [31:0] s_avl_readdata,
    output logic [1:0]  s_avl_response,
    output logic        s_avl_waitrequest,
    output logic        s_avl_readdatavalid,
    output logic        s_avl_writeresponsevalid
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, WRITE, READ, WRESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q;
    logic [2:0]    beats_q;
    logic [2:0]    beat_q;
    logic [1:0]    err_q;
    logic [31:0]   mem [DEPTH];

    logic          cmd;
    logic          accept;
    logic          waitreq;
    logic          last_wbeat;
    logic [AW-1:0] acc_base;
    logic [2:0]    acc_beats;
    logic [1:0]    acc_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          unused_lock;

    function automatic logic [1:0] decode_err(input logic [31:0] addr, input logic [2:0] bc);
        if ({1'b0, addr} >= (33'(DEPTH) << 2))
            return 2'b11;
        else if (bc > 3'(MAX_BURST))
            return 2'b10;
        return 2'b00;
    endfunction

    assign unused_lock = s_avl_lock;
    assign cmd         = s_avl_read | s_avl_write;
    assign acc_base    = s_avl_address[AW+1:2];
    assign acc_beats   = (s_avl_burstcount == 3'd0) ? 3'd1 : s_avl_burstcount;
    assign acc_err     = decode_err(s_avl_address, s_avl_burstcount);
    assign last_wbeat  = (beat_q == beats_q - 3'd1);

    // Held in reset the port must stall even when the idle state would not.
    assign s_avl_waitrequest = waitreq | ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waitreq = 1'b1;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    waitreq = 1'b0;
                    accept  = cmd;
                end else if (cmd) begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
            WAIT: begin
                if (!cmd) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'(WAIT_CYCLES)) begin
                    waitreq = 1'b0;
                    accept  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                waitreq = 1'b0;
                if (s_avl_write && last_wbeat)
                    state_d = WRESP;
            end
            READ: begin
                if (beat_q == beats_q)
                    state_d = IDLE;
            end
            WRESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (s_avl_write)
                state_d = (acc_beats == 3'd1) ? WRESP : WRITE;
            else
                state_d = READ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first beat of a command uses the live address; later beats walk from the latched base.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = base_q + AW'(beat_q);
        if (accept) begin
            mem_addr = acc_base;
            mem_we   = s_avl_write && (acc_err == 2'b00);
        end else if (state_q == WRITE && s_avl_write) begin
            mem_we = (err_q == 2'b00);
        end
        mem_we = mem_we & rst;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_avl_byteenable[b])
                    mem[mem_addr][8*b +: 8] <= s_avl_writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q                   <= '0;
            beats_q                  <= 3'd0;
            beat_q                   <= 3'd0;
            err_q                    <= 2'b00;
            s_avl_readdata           <= 32'd0;
            s_avl_response           <= 2'b00;
            s_avl_readdatavalid      <= 1'b0;
            s_avl_writeresponsevalid <= 1'b0;
        end else begin
            s_avl_readdatavalid      <= 1'b0;
            s_avl_writeresponsevalid <= 1'b0;
            if (accept) begin
                base_q  <= acc_base;
                beats_q <= acc_beats;
                err_q   <= acc_err;
                beat_q  <= 3'd1;
                if (!s_avl_write) begin
                    s_avl_readdatavalid <= 1'b1;
                    s_avl_readdata      <= (acc_err == 2'b00) ? mem[mem_addr] : 32'd0;
                    s_avl_response      <= acc_err;
                end else if (acc_beats == 3'd1) begin
                    s_avl_writeresponsevalid <= 1'b1;
                    s_avl_response           <= acc_err;
                end
            end else if (state_q == WRITE && s_avl_write) begin
                beat_q <= beat_q + 3'd1;
                if (last_wbeat) begin
                    s_avl_writeresponsevalid <= 1'b1;
                    s_avl_response           <= err_q;
                end
            end else if (state_q == READ && beat_q != beats_q) begin
                beat_q              <= beat_q + 3'd1;
                s_avl_readdatavalid <= 1'b1;
                s_avl_readdata      <= (err_q == 2'b00) ? mem[mem_addr] : 32'd0;
                s_avl_response      <= err_q;
            end
        end
    end

endmodule
